mult_div_unit: RTL

//  EX-stage iterative signed multiply/divide unit with architectural HI/LO registers.

---
 rtl/mult_div_unit_pkg.sv | 23 ++
 rtl/mult_div_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
//   ALU_mult / ALU_div : alu_control values that launch an op
//   move_high / move_low : move_hi_lo values that select an MFHI / MFLO read
//   mdu_state_e : FSM state codes
package mult_div_unit_pkg;

    localparam int unsigned ALU_CTRL_W = 5;
    localparam int unsigned MOVE_W     = 2;

    localparam logic [ALU_CTRL_W-1:0] ALU_mult = 5'd12;
    localparam logic [ALU_CTRL_W-1:0] ALU_div  = 5'd13;

    localparam logic [MOVE_W-1:0] move_none = 2'd0;
    localparam logic [MOVE_W-1:0] move_high = 2'd1;
    localparam logic [MOVE_W-1:0] move_low  = 2'd2;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative signed multiply/divide unit with architectural HI/LO registers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_i             EX holds a real instruction
//   alu_control         decoded op; ALU_mult / ALU_div launch an op
//   move_hi_lo          MFHI / MFLO select (0 = none)
//   src_a, src_b        multiplicand/dividend, multiplier/divisor
//   flush_i             kill EX instruction and abort any op in flight
//   busy_o              op in flight
//   stall_o             combinational freeze request for IF/ID/EX
//   hilo_out            HI or LO selected by move_hi_lo, else 0
//   hi_o, lo_o          architectural HI / LO
//   div_by_zero_o       one-cycle pulse when a DIV by zero completes
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITERS = WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [ALU_CTRL_W-1:0] alu_control,
    input  logic [MOVE_W-1:0]     move_hi_lo,
    input  logic [WIDTH-1:0]      src_a,
    input  logic [WIDTH-1:0]      src_b,
    input  logic                  flush_i,
    output logic                  busy_o,
    output logic                  stall_o,
    output logic [WIDTH-1:0]      hilo_out,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o,
    output logic                  div_by_zero_o
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned ACC_W = 2 * WIDTH + 1;

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + (2 * WIDTH)'(1);
    endfunction

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               dbz_q, dbz_d;

    logic               start_c;
    logic               mf_req_c;
    logic               op_div_c;
    logic [ACC_W-1:0]   step_c;
    logic [WIDTH:0]     mul_sum_c;
    logic [ACC_W-1:0]   div_shl_c;
    logic [WIDTH:0]     div_trial_c;
    logic               div_ge_c;
    logic [2*WIDTH-1:0] prod_c;
    logic [WIDTH-1:0]   res_hi_c;
    logic [WIDTH-1:0]   res_lo_c;

    // Request decode and pipeline stall
    always_comb begin
        op_div_c = (alu_control == ALU_div);
        start_c  = valid_i & ((alu_control == ALU_mult) | op_div_c);
        mf_req_c = valid_i & (move_hi_lo != move_none);
        stall_o  = busy_q & (start_c | mf_req_c);
    end

    // One radix-2 step: shift-add multiply or restoring shift-subtract divide
    always_comb begin
        mul_sum_c   = acc_q[ACC_W-1:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shl_c   = {acc_q[ACC_W-2:0], 1'b0};
        div_trial_c = div_shl_c[ACC_W-1:WIDTH] - {1'b0, opnd_q};
        div_ge_c    = (div_shl_c[ACC_W-1:WIDTH] >= {1'b0, opnd_q});
        if (is_div_q) begin
            step_c = div_ge_c ? {div_trial_c, div_shl_c[WIDTH-1:1], 1'b1} : div_shl_c;
        end else begin
            step_c = {1'b0, mul_sum_c, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result
    always_comb begin
        prod_c   = acc_q[2*WIDTH-1:0];
        res_hi_c = '0;
        res_lo_c = '0;
        if (sign_a_q ^ sign_b_q) begin
            prod_c = neg_2w(acc_q[2*WIDTH-1:0]);
        end
        if (!is_div_q) begin
            res_hi_c = prod_c[2*WIDTH-1:WIDTH];
            res_lo_c = prod_c[WIDTH-1:0];
        end else if (dz_q) begin
            res_hi_c = a_raw_q;
            res_lo_c = '1;
        end else begin
            // Quotient truncates toward zero; remainder follows dividend sign
            res_lo_c = (sign_a_q ^ sign_b_q) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
            res_hi_c = sign_a_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_raw_d  = a_raw_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        dbz_d    = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (start_c && !flush_i) begin
                    state_d  = MDU_RUN;
                    busy_d   = 1'b1;
                    count_d  = CNT_W'(ITERS - 1);
                    is_div_d = op_div_c;
                    sign_a_d = src_a[WIDTH-1];
                    sign_b_d = src_b[WIDTH-1];
                    a_raw_d  = src_a;
                    dz_d     = (src_b == '0);
                    // Divide: low half holds |dividend|, opnd is |divisor|.
                    // Multiply: low half holds |multiplier|, opnd is |multiplicand|.
                    opnd_d   = op_div_c ? abs_w(src_b) : abs_w(src_a);
                    acc_d    = {(WIDTH + 1)'(0), op_div_c ? abs_w(src_a) : abs_w(src_b)};
                end
            end
            MDU_RUN: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = step_c;
                    if (count_q == '0) begin
                        state_d = MDU_DONE;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                busy_d  = 1'b0;
                if (!flush_i) begin
                    hi_d  = res_hi_c;
                    lo_d  = res_lo_c;
                    dbz_d = is_div_q & dz_q;
                end
            end
            default: begin
                state_d = MDU_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MDU_IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_raw_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_raw_q  <= a_raw_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            dbz_q    <= dbz_d;
        end
    end

    // MFHI / MFLO read of the architectural registers
    always_comb begin
        hilo_out = '0;
        if (move_hi_lo == move_high) begin
            hilo_out = hi_q;
        end else if (move_hi_lo == move_low) begin
            hilo_out = lo_q;
        end
    end

    assign busy_o        = busy_q;
    assign hi_o          = hi_q;
    assign lo_o          = lo_q;
    assign div_by_zero_o = dbz_q;

endmodule
